serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/addsub_pkg.sv | 22 ++
 rtl/fas_cell.sv | 18 +
 rtl/serial_addsub.sv | 114 +++++++++++
 tb/tb_serial_addsub.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared encodings for the bit-serial adder/subtractor: operation modes,
// controller states and the signed-overflow rule.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement overflow from the operand and result sign bits.
    function automatic logic signed_ovf(input logic mode, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
        logic sign_cond;
        sign_cond = (mode == MODE_SUB) ? (a_msb != b_msb) : (a_msb == b_msb);
        return sign_cond && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/fas_cell.sv
// One-bit full adder / full subtractor; mode selects x+y+cin or x-y-bin.
module fas_cell
    import addsub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);

    // The sum/difference bit is identical; only the carry/borrow term differs.
    assign s    = x ^ y ^ cin;
    assign cout = (mode == MODE_SUB) ? ((~x & y) | (~(x ^ y) & cin))
                                     : ((x & y)  | ((x ^ y) & cin));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: latches operands on start, processes one bit per
// cycle LSB first, and presents registered result/cout/ovf with a done pulse.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic             load, step, last;
    logic [WIDTH-1:0] a_r, b_r;
    logic             mode_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic             cell_s, cell_cout;

    fas_cell u_cell (
        .x    (a_r[cnt[IW-1:0]]),
        .y    (b_r[cnt[IW-1:0]]),
        .cin  (carry),
        .mode (mode_r),
        .s    (cell_s),
        .cout (cell_cout)
    );

    // New bit enters at the MSB end; after WIDTH steps bit 0 sits at [0].
    assign shifted = {cell_s, sreg};

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last     = (cnt == LAST);
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) state_nx = ST_DONE;
            end
            ST_DONE: begin
                load     = start;
                state_nx = start ? ST_RUN : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= MODE_ADD;
            carry  <= 1'b0;
            cnt    <= '0;
            sreg   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            busy <= (state_nx == ST_RUN);
            done <= step && last;
            if (load) begin
                a_r    <= a;
                b_r    <= b;
                mode_r <= mode;
                carry  <= 1'b0;
                cnt    <= '0;
            end else if (step) begin
                carry <= cell_cout;
                sreg  <= shifted[WIDTH-1:1];
                if (last) begin
                    result <= shifted;
                    cout   <= cell_cout;
                    ovf    <= signed_ovf(mode_r, a_r[WIDTH-1], b_r[WIDTH-1], cell_s);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed vectors, back-to-back,
// ignored start, reset abort, random WIDTH=8 and exhaustive WIDTH=4.
module tb_serial_addsub;
    import addsub_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start8, mode8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, res8;
    logic       start4, mode4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, res4;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
    );

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .cout(cout4), .ovf(ovf4)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int res;
        int co;
        int ov;
    } exp_t;

    typedef struct {
        logic m;
        int   x;
        int   y;
        int   res;
        int   co;
        int   ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input logic m, input int x, input int y);
        exp_t e;
        int half, full, sx, sy, sr;
        half = 1 << (w - 1);
        full = 1 << w;
        sx = (x >= half) ? x - full : x;
        sy = (y >= half) ? y - full : y;
        if (m == MODE_ADD) begin
            e.res = (x + y) % full;
            e.co  = int'((x + y) >= full);
            sr    = sx + sy;
        end else begin
            e.res = (x - y + full) % full;
            e.co  = int'(x < y);
            sr    = sx - sy;
        end
        e.ov = int'((sr >= half) || (sr < -half));
        return e;
    endfunction

    task automatic drive(input int w, input logic st, input logic m, input int x, input int y);
        if (w == 8) begin
            start8 = st; mode8 = m; a8 = x[7:0]; b8 = y[7:0];
        end else begin
            start4 = st; mode4 = m; a4 = x[3:0]; b4 = y[3:0];
        end
    endtask

    task automatic sample(input int w, output logic bz, output logic dn, output int r,
                          output logic co, output logic ov);
        if (w == 8) begin
            bz = busy8; dn = done8; r = int'(res8); co = cout8; ov = ovf8;
        end else begin
            bz = busy4; dn = done4; r = int'(res4); co = cout4; ov = ovf4;
        end
    endtask

    // Called at a negedge; launches one operation and waits (bounded) for done.
    // Operand inputs are scrambled after the start edge; a second start can be
    // pulsed at negedge number 'glitch' to confirm it is ignored.
    task automatic op(input int w, input logic m, input int x, input int y, input int glitch,
                      output int r, output logic co, output logic ov,
                      output int lat, output int nbusy);
        logic bz, dn;
        drive(w, 1'b1, m, x, y);
        @(posedge clk); #1;
        drive(w, 1'b0, 1'($urandom_range(0, 1)), int'($urandom), int'($urandom));
        lat = 0; nbusy = 0; dn = 1'b0;
        while (!dn && lat < 40) begin
            @(negedge clk);
            lat++;
            sample(w, bz, dn, r, co, ov);
            if (bz) nbusy++;
            if (lat == glitch) begin
                drive(w, 1'b1, ~m, int'($urandom), int'($urandom));
                @(posedge clk); #1;
                drive(w, 1'b0, m, x, y);
            end
        end
    endtask

    task automatic op_check(input string tag, input int w, input logic m, input int x,
                            input int y, input int glitch);
        int r, lat, nbusy;
        logic co, ov;
        exp_t e;
        e = model(w, m, x, y);
        op(w, m, x, y, glitch, r, co, ov, lat, nbusy);
        check({tag, " latency"}, lat, w + 1);
        check({tag, " result"}, r, e.res);
        check({tag, " cout"}, 32'(co), e.co);
        check({tag, " ovf"}, 32'(ov), e.ov);
    endtask

    initial begin
        vec_t vecs[8];
        int   r, lat, nbusy, ndone;
        logic co, ov, bz, dn;

        vecs[0] = '{MODE_ADD, 'h7F, 'h01, 'h80, 0, 1};
        vecs[1] = '{MODE_SUB, 'h00, 'h01, 'hFF, 1, 0};
        vecs[2] = '{MODE_SUB, 'h80, 'h01, 'h7F, 0, 1};
        vecs[3] = '{MODE_ADD, 'hFF, 'h01, 'h00, 1, 0};
        vecs[4] = '{MODE_SUB, 'h05, 'h03, 'h02, 0, 0};
        vecs[5] = '{MODE_ADD, 'h80, 'h80, 'h00, 1, 1};
        vecs[6] = '{MODE_SUB, 'h7F, 'hFF, 'h80, 1, 1};
        vecs[7] = '{MODE_ADD, 'h12, 'h34, 'h46, 0, 0};

        rst_n = 1'b0;
        drive(8, 1'b0, MODE_ADD, 0, 0);
        drive(4, 1'b0, MODE_ADD, 0, 0);
        repeat (2) @(negedge clk);
        check("reset busy8", 32'(busy8), 0);
        check("reset done8", 32'(done8), 0);
        check("reset result8", 32'(res8), 0);
        check("reset cout8", 32'(cout8), 0);
        check("reset ovf8", 32'(ovf8), 0);
        check("reset busy4", 32'(busy4), 0);
        check("reset done4", 32'(done4), 0);
        rst_n = 1'b1;

        // Start in the first cycle after reset release, then the directed table.
        for (int i = 0; i < 8; i++) begin
            op(8, vecs[i].m, vecs[i].x, vecs[i].y, 0, r, co, ov, lat, nbusy);
            check($sformatf("vec%0d latency", i), lat, 9);
            check($sformatf("vec%0d busy cycles", i), nbusy, 8);
            check($sformatf("vec%0d result", i), r, vecs[i].res);
            check($sformatf("vec%0d cout", i), 32'(co), vecs[i].co);
            check($sformatf("vec%0d ovf", i), 32'(ov), vecs[i].ov);
            @(negedge clk);
            sample(8, bz, dn, r, co, ov);
            check($sformatf("vec%0d done pulse width", i), 32'(dn), 0);
            check($sformatf("vec%0d result hold", i), r, vecs[i].res);
        end

        // Back-to-back: second start issued in the done cycle of the first.
        op_check("b2b first", 8, MODE_ADD, 'hFF, 'h01, 0);
        op_check("b2b second", 8, MODE_SUB, 'h05, 'h03, 0);

        // A start pulsed mid-operation must be ignored.
        op_check("ignored start", 8, MODE_ADD, 'h3C, 'h55, 2);
        repeat (3) @(negedge clk);

        // Reset during an operation: abort with no done, reset beats start.
        drive(8, 1'b1, MODE_ADD, 'h12, 'h34);
        @(posedge clk); #1;
        drive(8, 1'b0, MODE_SUB, 'hAA, 'h55);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy8), 0);
        check("abort done", 32'(done8), 0);
        check("abort result", 32'(res8), 0);
        check("abort cout", 32'(cout8), 0);
        check("abort ovf", 32'(ovf8), 0);
        drive(8, 1'b1, MODE_ADD, 'h01, 'h01);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        check("reset dominates start", ndone, 0);
        rst_n = 1'b1;
        op_check("after abort", 8, MODE_SUB, 'h7F, 'h80, 0);

        // Randomized WIDTH=8 operations, some with idle gaps.
        for (int i = 0; i < 40; i++) begin
            op_check($sformatf("rand%0d", i), 8, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Exhaustive WIDTH=4, both modes.
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    op_check($sformatf("w4 m%0d %0d,%0d", m, x, y), 4, 1'(m), x, y, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
